apb4_master_arb: RTL and testbench

- Round-robin arbiter and APB4 master sequencer that shares one APB4 master port between REQ_NUM simple request/acknowledge requesters.
- Typical requesters are the boot CPU and a debug bridge; the shared resource is an APB4 peripheral segment such as apb4_archinfo.
- Serialises transfers, generates the SETUP/ACCESS phases and waits on pready_i.
- An optional watchdog aborts transfers whose slave never responds.

---
 rtl/apb4_master_arb_if.sv | 39 +++
 rtl/apb4_master_arb.sv | 136 +++++++++++++
 tb/tb_apb4_master_arb.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/apb4_master_arb_if.sv
// apb4_master_arb_if: requester-side and APB4-side signals of the shared APB4 master port
interface apb4_master_arb_if #(
    parameter int REQ_NUM    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [REQ_NUM-1:0]              req_i;
    logic [REQ_NUM*ADDR_WIDTH-1:0]   addr_i;
    logic [REQ_NUM-1:0]              write_i;
    logic [REQ_NUM*DATA_WIDTH-1:0]   wdata_i;
    logic [REQ_NUM*DATA_WIDTH/8-1:0] wstrb_i;
    logic [REQ_NUM-1:0]              ack_o;
    logic [DATA_WIDTH-1:0]           rdata_o;
    logic                            err_o;
    logic [REQ_NUM-1:0]              grant_o;
    logic                            busy_o;
    logic [ADDR_WIDTH-1:0]           paddr_o;
    logic [2:0]                      pprot_o;
    logic                            psel_o;
    logic                            penable_o;
    logic                            pwrite_o;
    logic [DATA_WIDTH-1:0]           pwdata_o;
    logic [DATA_WIDTH/8-1:0]         pstrb_o;
    logic [DATA_WIDTH-1:0]           prdata_i;
    logic                            pready_i;
    logic                            pslverr_i;

    modport master (
        input  req_i, addr_i, write_i, wdata_i, wstrb_i, prdata_i, pready_i, pslverr_i,
        output ack_o, rdata_o, err_o, grant_o, busy_o, paddr_o, pprot_o, psel_o,
               penable_o, pwrite_o, pwdata_o, pstrb_o
    );

    modport slave (
        output req_i, addr_i, write_i, wdata_i, wstrb_i, prdata_i, pready_i, pslverr_i,
        input  ack_o, rdata_o, err_o, grant_o, busy_o, paddr_o, pprot_o, psel_o,
               penable_o, pwrite_o, pwdata_o, pstrb_o
    );
endinterface

// File: rtl/apb4_master_arb.sv
// apb4_master_arb: round-robin arbiter sequencing REQ_NUM requesters onto one APB4 master port
module apb4_master_arb #(
    parameter int REQ_NUM    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input logic clk_i,
    input logic rst_n_i,
    apb4_master_arb_if.master bus
);
    localparam int LW = REQ_NUM > 1 ? $clog2(REQ_NUM) : 1;
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [LW-1:0] LAST_RST = LW'(REQ_NUM - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                  state, state_n;
    logic [LW-1:0]           last, last_n, win;
    logic                    found;
    logic [CW-1:0]           cnt, cnt_n;
    logic [REQ_NUM-1:0]      grant_n, ack_n;
    logic [ADDR_WIDTH-1:0]   paddr_n;
    logic [DATA_WIDTH-1:0]   pwdata_n, rdata_n;
    logic [SW-1:0]           pstrb_n;
    logic                    pwrite_n, psel_n, penable_n, err_n;

    assign bus.pprot_o = 3'b000;

    // first requesting index after the previous owner, wrapping around
    always_comb begin
        int k;
        found = 1'b0;
        win   = last;
        for (int i = 1; i <= REQ_NUM; i++) begin
            k = (int'(last) + i) % REQ_NUM;
            if (!found && bus.req_i[k]) begin
                found = 1'b1;
                win   = LW'(k);
            end
        end
    end

    always_comb begin
        state_n   = state;
        last_n    = last;
        cnt_n     = cnt;
        grant_n   = bus.grant_o;
        ack_n     = '0;
        paddr_n   = bus.paddr_o;
        pwrite_n  = bus.pwrite_o;
        pwdata_n  = bus.pwdata_o;
        pstrb_n   = bus.pstrb_o;
        psel_n    = bus.psel_o;
        penable_n = bus.penable_o;
        rdata_n   = bus.rdata_o;
        err_n     = bus.err_o;
        case (state)
            IDLE: if (found) begin
                state_n  = SETUP;
                last_n   = win;
                cnt_n    = '0;
                grant_n  = REQ_NUM'(1) << win;
                paddr_n  = bus.addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
                pwrite_n = bus.write_i[win];
                pwdata_n = bus.wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
                pstrb_n  = bus.write_i[win] ? bus.wstrb_i[win*SW +: SW] : '0;
                psel_n   = 1'b1;
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
            end
            ACCESS: if (bus.pready_i) begin
                state_n   = DONE;
                rdata_n   = bus.prdata_i;
                err_n     = bus.pslverr_i;
                psel_n    = 1'b0;
                penable_n = 1'b0;
                ack_n     = bus.grant_o;
            end else begin
                cnt_n = cnt + CW'(1);
                if (TIMEOUT != 0 && cnt == TO_LAST) begin
                    state_n   = DONE;
                    rdata_n   = '0;
                    err_n     = 1'b1;
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    ack_n     = bus.grant_o;
                end
            end
            default: begin
                state_n = IDLE;
                rdata_n = '0;
                err_n   = 1'b0;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            last          <= LAST_RST;
            cnt           <= '0;
            bus.grant_o   <= '0;
            bus.ack_o     <= '0;
            bus.busy_o    <= 1'b0;
            bus.paddr_o   <= '0;
            bus.pwrite_o  <= 1'b0;
            bus.pwdata_o  <= '0;
            bus.pstrb_o   <= '0;
            bus.psel_o    <= 1'b0;
            bus.penable_o <= 1'b0;
            bus.rdata_o   <= '0;
            bus.err_o     <= 1'b0;
        end else begin
            state         <= state_n;
            last          <= last_n;
            cnt           <= cnt_n;
            bus.grant_o   <= grant_n;
            bus.ack_o     <= ack_n;
            bus.busy_o    <= state_n != IDLE;
            bus.paddr_o   <= paddr_n;
            bus.pwrite_o  <= pwrite_n;
            bus.pwdata_o  <= pwdata_n;
            bus.pstrb_o   <= pstrb_n;
            bus.psel_o    <= psel_n;
            bus.penable_o <= penable_n;
            bus.rdata_o   <= rdata_n;
            bus.err_o     <= err_n;
        end
    end
endmodule

// File: tb/tb_apb4_master_arb.sv
// tb_apb4_master_arb: directed checks of arbitration, APB phasing, errors, timeout and reset
module tb_apb4_master_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int n;
    int acc;
    int acks;

    always #5 clk = ~clk;

    apb4_master_arb_if #(.REQ_NUM(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) b ();
    apb4_master_arb_if #(.REQ_NUM(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) s ();

    apb4_master_arb #(.REQ_NUM(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(b)
    );
    apb4_master_arb #(.REQ_NUM(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) dut_nt (
        .clk_i(clk), .rst_n_i(rst_n), .bus(s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int lim);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b.ack_o == 2'b00 && n < lim);
        chk("ack_seen", 64'(b.ack_o != 2'b00), 64'd1);
    endtask

    initial begin
        {b.req_i, b.addr_i, b.write_i, b.wdata_i, b.wstrb_i} = '0;
        {s.req_i, s.addr_i, s.write_i, s.wdata_i, s.wstrb_i} = '0;
        b.prdata_i = '0; b.pready_i = 1'b1; b.pslverr_i = 1'b0;
        s.prdata_i = '0; s.pready_i = 1'b0; s.pslverr_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_psel", b.psel_o, 0);
        chk("rst_ack", b.ack_o, 0);
        chk("rst_busy", b.busy_o, 0);
        chk("rst_grant", b.grant_o, 0);
        chk("rst_paddr", b.paddr_o, 0);
        chk("rst_pprot", b.pprot_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single write by requester 0
        b.req_i = 2'b01; b.write_i = 2'b01;
        b.addr_i = {32'h0, 32'h0000_0004};
        b.wdata_i = {32'h0, 32'hDEAD_BEEF};
        b.wstrb_i = {4'h0, 4'hF};
        @(negedge clk);
        chk("wr_c1_psel", b.psel_o, 1);
        chk("wr_c1_penable", b.penable_o, 0);
        chk("wr_c1_grant", b.grant_o, 2'b01);
        chk("wr_c1_busy", b.busy_o, 1);
        chk("wr_c1_paddr", b.paddr_o, 32'h4);
        chk("wr_c1_pwrite", b.pwrite_o, 1);
        chk("wr_c1_pwdata", b.pwdata_o, 32'hDEAD_BEEF);
        chk("wr_c1_pstrb", b.pstrb_o, 4'hF);
        @(negedge clk);
        chk("wr_c2_penable", b.penable_o, 1);
        chk("wr_c2_ack", b.ack_o, 0);
        @(negedge clk);
        chk("wr_c3_ack", b.ack_o, 2'b01);
        chk("wr_c3_err", b.err_o, 0);
        chk("wr_c3_psel", b.psel_o, 0);
        chk("wr_c3_pstrb", b.pstrb_o, 4'hF);
        b.req_i = 2'b00;
        @(negedge clk);
        chk("wr_c4_ack", b.ack_o, 0);
        chk("wr_c4_busy", b.busy_o, 0);
        chk("wr_c4_grant", b.grant_o, 0);

        // read by requester 1 with three wait states
        b.req_i = 2'b10; b.write_i = 2'b00; b.addr_i = '0;
        b.wstrb_i = {4'hF, 4'hF};
        b.pready_i = 1'b0; b.prdata_i = 32'h1234_5678;
        acc = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (b.psel_o) chk("rd_pstrb", b.pstrb_o, 0);
            if (b.penable_o) begin
                acc++;
                if (acc == 4) b.pready_i = 1'b1;
            end
        end while (b.ack_o == 2'b00 && n < 20);
        chk("rd_access_cycles", acc, 4);
        chk("rd_ack", b.ack_o, 2'b10);
        chk("rd_rdata", b.rdata_o, 32'h1234_5678);
        chk("rd_err", b.err_o, 0);
        chk("rd_paddr", b.paddr_o, 0);
        chk("rd_pwrite", b.pwrite_o, 0);
        b.req_i = 2'b00;
        @(negedge clk);
        chk("rd_rdata_clr", b.rdata_o, 0);

        // both requesters held: strict alternation starting at 0
        b.req_i = 2'b11;
        for (int t = 0; t < 6; t++) begin
            wait_ack(10);
            chk("rr_ack", b.ack_o, (t % 2) ? 2'b10 : 2'b01);
            chk("rr_grant", b.grant_o, (t % 2) ? 2'b10 : 2'b01);
            if (t == 5) b.req_i = 2'b00;
        end
        @(negedge clk);

        // slave error, then a clean back-to-back transfer
        b.req_i = 2'b01; b.write_i = 2'b01; b.pslverr_i = 1'b1;
        wait_ack(10);
        chk("se_ack", b.ack_o, 2'b01);
        chk("se_err", b.err_o, 1);
        b.pslverr_i = 1'b0;
        wait_ack(10);
        chk("se_next_err", b.err_o, 0);
        b.req_i = 2'b00;
        @(negedge clk);

        // watchdog abort after 16 ACCESS cycles
        b.req_i = 2'b01; b.write_i = 2'b00; b.pready_i = 1'b0; b.prdata_i = 32'hAAAA_5555;
        acc = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (b.penable_o) acc++;
        end while (b.ack_o == 2'b00 && n < 40);
        chk("to_access_cycles", acc, 16);
        chk("to_ack", b.ack_o, 2'b01);
        chk("to_err", b.err_o, 1);
        chk("to_rdata", b.rdata_o, 0);
        chk("to_psel", b.psel_o, 0);
        b.req_i = 2'b00;
        @(negedge clk);

        // no watchdog: stuck slave never completes
        s.req_i = 2'b01;
        acks = 0;
        repeat (1000) begin
            @(negedge clk);
            if (s.ack_o != 2'b00) acks++;
        end
        chk("nt_acks", acks, 0);
        chk("nt_psel", s.psel_o, 1);
        chk("nt_busy", s.busy_o, 1);

        // reset during wait states of requester 1
        b.req_i = 2'b10; b.pready_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("mr_penable_before", b.penable_o, 1);
        chk("mr_grant_before", b.grant_o, 2'b10);
        rst_n = 1'b0; b.req_i = 2'b11; b.pready_i = 1'b1;
        @(negedge clk);
        chk("mr_psel", b.psel_o, 0);
        chk("mr_penable", b.penable_o, 0);
        chk("mr_ack", b.ack_o, 0);
        chk("mr_busy", b.busy_o, 0);
        chk("mr_grant", b.grant_o, 0);
        chk("mr_paddr", b.paddr_o, 0);
        chk("mr_nt_psel", s.psel_o, 0);
        rst_n = 1'b1; s.req_i = 2'b00;
        wait_ack(10);
        chk("mr_reissue_ack", b.ack_o, 2'b01);
        chk("mr_reissue_err", b.err_o, 0);
        b.req_i = 2'b00;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
